// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: the instruction-memory request/return pair, the redirect
// input and the valid/ready handshake towards decode.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misalign;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_misalign,
    input  imem_rdata, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_misalign,
    output imem_rdata, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues word reads to a 1-cycle synchronous imem and buffers
// {pc, instr} in a 2-entry skid FIFO for decode. Option macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [31:0] target_pc;
  entry_t      push_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        halt_q, halt_d;
  logic        trap_pend_q, trap_pend_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        target_misaligned;
`else
  logic        unused_redirect_lo;
  assign unused_redirect_lo = ^bus.redirect_pc[1:0];
`endif

  assign pop = (count_q != 2'd0) && bus.id_ready;

  always_comb begin
    // NOTE: next-state logic uses blocking '=' and defaults every variable it
    // writes before any branch, so no path can infer a latch.
    pc_d             = pc_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    fifo_d           = fifo_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    count_d          = count_q;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = bus.imem_rdata;
    // Credit: a slot is free for a new read once buffered + in-flight fits, counting this pop.
    occupancy        = {1'b0, count_q} + {2'b00, inflight_q};
    issue            = !bus.redirect_valid && (occupancy < DEPTH + {2'b00, pop});
    push             = !bus.redirect_valid && inflight_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    halt_d              = halt_q;
    trap_pend_d         = 1'b0;
    trap_pc_d           = trap_pc_q;
    push_entry.misalign = 1'b0;
    target_pc           = bus.redirect_pc;
    target_misaligned   = (bus.redirect_pc[1:0] != 2'b00);
    issue               = issue && !halt_q;
    // The trap marker is the only push while halted, so it never collides with a return.
    if (trap_pend_q) begin
      push                = !bus.redirect_valid;
      push_entry.pc       = trap_pc_q;
      push_entry.instr    = 32'h0000_0013;
      push_entry.misalign = 1'b1;
    end
`else
    target_pc = {bus.redirect_pc[31:2], 2'b00};
`endif

    if (bus.redirect_valid) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_d      = target_misaligned;
      trap_pend_d = target_misaligned;
      if (target_misaligned) trap_pc_d = target_pc;
      else                   pc_d      = target_pc;
`else
      pc_d = target_pc;
`endif
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_STEP;
      end
      if (push) begin
        fifo_d[wr_ptr_q] = push_entry;
        wr_ptr_d         = !wr_ptr_q;
      end
      if (pop) rd_ptr_d = !rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: the two FIFO slots are reset as well, because the head must read
  // as zero while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= 1'b0;
      trap_pend_q   <= 1'b0;
      trap_pc_q     <= '0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fifo_q        <= fifo_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      halt_q        <= halt_d;
      trap_pend_q   <= trap_pend_d;
      trap_pc_q     <= trap_pc_d;
`endif
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = (count_q != 2'd0);
  assign bus.if_instr  = fifo_q[rd_ptr_q].instr;
  assign bus.if_pc     = fifo_q[rd_ptr_q].pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.if_misalign = fifo_q[rd_ptr_q].misalign;
`else
  assign bus.if_misalign = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(push && count_q == 2'd2));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    !(pop && count_q == 2'd0));

endmodule
